// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives a combinational word-addressed
// imem, and registers instructions into a valid/ready stage with J/JAL folding.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd160,
  parameter int          IMEM_WORDS = 250,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             link_valid,
  output logic [31:0]      link_addr,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic {RUN, HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, r_if_instr, r_if_pc;
  logic             r_if_valid, r_fault;
  logic [CNT_W-1:0] r_count;

  logic        w_load, w_pc_bad, w_is_jump;
  logic [31:0] w_pc4, w_next_pc;
  logic        w_take, w_redir, w_flush, w_fault_set, w_deliver;

  assign w_load    = !r_if_valid || if_ready;
  assign w_pc_bad  = (r_pc >= PC_LIMIT) || (r_pc[1:0] != 2'b00);
  assign w_pc4     = r_pc + 32'd4;
  assign w_is_jump = (imem_instr[31:26] == 6'b000010) || (imem_instr[31:26] == 6'b000011);
  // J/JAL folded here so the target is presented on the very next cycle.
  assign w_next_pc = w_is_jump ? {w_pc4[31:28], imem_instr[25:0], 2'b00} : w_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_redir     = 1'b0;
    w_flush     = 1'b0;
    w_fault_set = 1'b0;
    w_deliver   = 1'b0;
    if (r_state == RUN) begin
      // A flushed instruction never counts as handed over, even with if_ready high.
      w_deliver = r_if_valid && if_ready && !redirect_valid;
      if (redirect_valid) begin
        w_flush = 1'b1;
        if (redirect_target[1:0] != 2'b00) begin
          w_fault_set = 1'b1;
          w_state_nxt = HALT;
        end else begin
          w_redir = 1'b1;
        end
      end else if (w_load) begin
        if (w_pc_bad) begin
          w_flush     = 1'b1;
          w_fault_set = 1'b1;
          w_state_nxt = HALT;
        end else begin
          w_take = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_fault_set) r_fault    <= 1'b1;
      if (w_flush)     r_if_valid <= 1'b0;
      if (w_redir)     r_pc       <= redirect_target;
      if (w_take) begin
        r_if_instr <= imem_instr;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
        r_pc       <= w_next_pc;
      end
      if (w_deliver && (r_count != {CNT_W{1'b1}})) r_count <= r_count + 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign fault       = r_fault;
  assign fetch_count = r_count;
  assign link_valid  = r_if_valid && (r_if_instr[31:26] == 6'b000011);
  assign link_addr   = r_if_valid ? (r_if_pc + 32'd4) : 32'd0;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences the combinational, word-addressed instruction memory (byte address in, word = address>>2, 32-bit instruction out). Each cycle it presents the PC, registers the returned instruction into a valid/ready output stage for decode, and folds in early J/JAL redirection. It also handles late branch redirects from execute, back-pressure stalls and out-of-range/misaligned faults. Sits between the instruction memory and the decode stage.

Parameters:
RESET_PC, 32'd160, byte address loaded into PC at reset (word 40, first program word).
IMEM_WORDS, 250, instruction memory depth in words; valid byte range is 0 .. IMEM_WORDS*4-4.
CNT_W, 16, width of delivered-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_addr  out  32  byte address driven to instruction memory; always equals PC register.
imem_instr  in  32  instruction returned combinationally for imem_addr.
redirect_valid  in  1  execute-stage branch taken (e.g. BEQ), one-cycle pulse.
redirect_target  in  32  byte target for redirect.
if_valid  out  1  output stage holds a valid instruction.
if_ready  in  1  decode accepts output this cycle.
if_instr  out  32  registered instruction.
if_pc  out  32  byte address of if_instr.
link_valid  out  1  if_instr is JAL (opcode 6'b000011); qualifies link_addr.
link_addr  out  32  if_pc + 4, return address for $ra.
fault  out  1  sticky; set on entry to HALT.
fetch_count  out  CNT_W  instructions handed to decode (if_valid & if_ready), saturating.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, state RUN, if_valid=0, if_instr=0, if_pc=0, fault=0, fetch_count=0; link_valid=0.
- States: RUN (fetching), HALT (no fetch, terminal until reset). No other states.
- Accept condition (RUN): load = !if_valid | if_ready. On load edge: if_instr<=imem_instr, if_pc<=PC, if_valid<=1, PC<=next_pc. If !load: PC and output stage hold (stall), zero memory side effects.
- next_pc: opcode imem_instr[31:26]==000010 (J) or 000011 (JAL) -> {PC+4[31:28], imem_instr[25:0], 2'b00}; else PC+4. Arithmetic mod 2^32. No delay slot.
- Latency: instruction at PC appears on if_* one edge after PC is presented; J/JAL target fetched on the very next cycle (zero bubble).
- Redirect (highest priority, RUN): redirect_valid=1 at edge -> PC<=redirect_target, if_valid<=0 regardless of if_ready (held/younger instruction flushed; fetch_count not incremented for it even if if_ready=1 same cycle). One bubble follows.
- Fault: enter HALT, fault<=1, if_valid<=0 when (a) redirect_target[1:0]!=0, or (b) RUN with PC>=IMEM_WORDS*4 or PC[1:0]!=0 at a would-be load (nothing latched). Fault check on redirect precedes PC update; PC keeps offending value for debug.
- HALT: imem_addr=PC held, if_valid=0, inputs ignored; exit only via rst_n.
- fetch_count increments on if_valid&if_ready edge, saturates at all-ones.
- link_valid/link_addr are combinational from if_instr/if_pc, gated by if_valid.
- Reset mid-stall or mid-redirect: immediate return to reset values; no partial state.

Test Plan:
- Reset release, if_ready=1: edge1 if_pc=160, if_instr=0x20080002; edge2 if_pc=164; fetch_count=1 after edge2.
- Hold if_ready=0 3 cycles after first load: if_pc stays 160, imem_addr stays 164, fetch_count unchanged; release -> if_pc=164 next edge.
- Fetch JAL at 196 (0x0C000028): next edge if_pc=196, link_valid=1, link_addr=200; following edge if_pc=160 (no bubble).
- redirect_valid with target 180 while if_valid=1, if_ready=1: if_valid=0 next cycle, fetch_count not incremented, then if_pc=180.
- redirect_target=0x00000102 -> fault=1, if_valid=0, stays HALT despite further redirects; rst_n low clears fault, PC=160.
- Redirect to 1000 (=IMEM_WORDS*4): next cycle fault=1, no instruction delivered.
